vlen_sched: RTL and testbench

Round-robin scheduler that shares one vector-length engine (3 multipliers, 3-input adder, square root) among NREQ collision-detection requesters. It grants one requester at a time, latches that requester's six IEEE-754 single-precision operands onto the engine inputs, and pulses the engine's active-low reset to start a computation. It then waits for the engine's ready flag, returns the result tagged with the requester ID, and puts the engine back into reset. It sits between the per-object collision units and the single shared engine instance.

---
 rtl/vlen_sched.sv | 176 +++++++++++++++++
 tb/tb_vlen_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlen_sched.sv
// vlen_sched: round-robin scheduler that shares one vector-length engine among NREQ requesters.
// Optional watchdog on the RUN wait is compiled in with `define VLEN_SCHED_TIMEOUT_EN.
module vlen_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK2,
    input  logic                RST,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*96-1:0]  ops_a,
    input  logic [NREQ*96-1:0]  ops_b,
    output logic [NREQ-1:0]     gnt,
    output logic [31:0]         eng_a1,
    output logic [31:0]         eng_a2,
    output logic [31:0]         eng_a3,
    output logic [31:0]         eng_b1,
    output logic [31:0]         eng_b2,
    output logic [31:0]         eng_b3,
    output logic                eng_rst_n,
    input  logic                eng_rdy,
    input  logic [31:0]         eng_res,
    output logic [31:0]         res,
    output logic [IDW-1:0]      res_id,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

`ifdef VLEN_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
`else
    localparam int CNT_W = 1;
`endif
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t           state_r;
    state_t           next_s;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   gid_r;
    logic [IDW-1:0]   sel_s;
    logic [IDW-1:0]   ptr_next_s;
    logic [NREQ-1:0]  onehot_s;
    logic             found_s;
    logic             timeout_s;
    logic [CNT_W-1:0] cnt_r;
    logic [95:0]      opa_s [NREQ];
    logic [95:0]      opb_s [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign opa_s[g] = ops_a[96*g +: 96];
        assign opb_s[g] = ops_b[96*g +: 96];
    end

    // Rotating-priority pick: first requesting index at or after ptr, wrapping.
    always_comb begin
        int j;
        j        = 0;
        found_s  = 1'b0;
        sel_s    = {IDW{1'b0}};
        onehot_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_r) + i) % NREQ;
            if (!found_s && req[IDW'(j)]) begin
                found_s = 1'b1;
                sel_s   = IDW'(j);
            end else begin
                found_s = found_s;
            end
        end
        onehot_s[sel_s] = found_s;
        if (gid_r == IDW'(NREQ - 1)) begin
            ptr_next_s = {IDW{1'b0}};
        end else begin
            ptr_next_s = gid_r + IDW'(1);
        end
    end

    // Next-state logic; a ready flag seen on the first RUN cycle may be stale and is masked.
    always_comb begin
        next_s    = state_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    next_s = LOAD;
                end else begin
                    next_s = IDLE;
                end
            end
            LOAD: next_s = RUN;
            RUN: begin
                if (eng_rdy && (cnt_r != {CNT_W{1'b0}})) begin
                    next_s = CAPTURE;
`ifdef VLEN_SCHED_TIMEOUT_EN
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    // The counter reaches TIMEOUT on this edge: give up on the engine.
                    next_s    = CAPTURE;
                    timeout_s = 1'b1;
`endif
                end else begin
                    next_s = RUN;
                end
            end
            CAPTURE: next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State, grant, operand, counter and result registers.
    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            ptr_r     <= {IDW{1'b0}};
            gid_r     <= {IDW{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            gnt       <= {NREQ{1'b0}};
            eng_a1    <= 32'h0;
            eng_a2    <= 32'h0;
            eng_a3    <= 32'h0;
            eng_b1    <= 32'h0;
            eng_b2    <= 32'h0;
            eng_b3    <= 32'h0;
            eng_rst_n <= 1'b0;
            res       <= 32'h0;
            res_id    <= {IDW{1'b0}};
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= next_s;
            eng_rst_n <= (next_s == RUN);
            done      <= 1'b0;
            err       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        gnt    <= onehot_s;
                        gid_r  <= sel_s;
                        eng_a1 <= opa_s[sel_s][31:0];
                        eng_a2 <= opa_s[sel_s][63:32];
                        eng_a3 <= opa_s[sel_s][95:64];
                        eng_b1 <= opb_s[sel_s][31:0];
                        eng_b2 <= opb_s[sel_s][63:32];
                        eng_b3 <= opb_s[sel_s][95:64];
                    end
                end
                LOAD: cnt_r <= {CNT_W{1'b0}};
                RUN: begin
`ifdef VLEN_SCHED_TIMEOUT_EN
                    cnt_r <= cnt_r + CNT_W'(1);
`else
                    cnt_r <= 1'b1;
`endif
                    // Result is registered on entry to CAPTURE so it is valid with done.
                    if (next_s == CAPTURE) begin
                        done   <= 1'b1;
                        err    <= timeout_s;
                        res    <= timeout_s ? QNAN : eng_res;
                        res_id <= gid_r;
                        ptr_r  <= ptr_next_s;
                    end
                end
                CAPTURE: gnt <= {NREQ{1'b0}};
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vlen_sched.sv
// Self-checking bench for vlen_sched: vector table, directed corner sequences, and a
// randomized run checked against a rotating-priority reference model.
module tb_vlen_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 20;

    logic              CLK2 = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   req;
    logic [NREQ*96-1:0] ops_a;
    logic [NREQ*96-1:0] ops_b;
    logic [NREQ-1:0]   gnt;
    logic [31:0]       eng_a1, eng_a2, eng_a3, eng_b1, eng_b2, eng_b3;
    logic              eng_rst_n;
    logic              eng_rdy;
    logic [31:0]       eng_res;
    logic [31:0]       res;
    logic [IDW-1:0]    res_id;
    logic              done;
    logic              err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   eng_lat = 5;
    int   ecnt    = 0;
    logic mrdy        = 1'b0;
    logic stale_force = 1'b0;
    logic [31:0] opa [NREQ][3];
    logic [31:0] opb [NREQ][3];

    vlen_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
        .CLK2(CLK2), .RST(RST), .req(req), .ops_a(ops_a), .ops_b(ops_b), .gnt(gnt),
        .eng_a1(eng_a1), .eng_a2(eng_a2), .eng_a3(eng_a3),
        .eng_b1(eng_b1), .eng_b2(eng_b2), .eng_b3(eng_b3),
        .eng_rst_n(eng_rst_n), .eng_rdy(eng_rdy), .eng_res(eng_res),
        .res(res), .res_id(res_id), .done(done), .err(err)
    );

    always #5 CLK2 = ~CLK2;

    // Stand-in engine: any function sensitive to all six operands, placed distinctly.
    function automatic logic [31:0] eng_fn(input logic [31:0] a1, input logic [31:0] a2,
                                           input logic [31:0] a3, input logic [31:0] b1,
                                           input logic [31:0] b2, input logic [31:0] b3);
        return ((a1 ^ b1 ^ 32'h4110_0000) + a2 + b3) + (a3 ^ {b2[15:0], b2[31:16]});
    endfunction

    assign eng_rdy = mrdy | stale_force;
    assign eng_res = eng_fn(eng_a1, eng_a2, eng_a3, eng_b1, eng_b2, eng_b3);

    function automatic logic [31:0] exp_res(input int i);
        return eng_fn(opa[i][0], opa[i][1], opa[i][2], opb[i][0], opb[i][1], opb[i][2]);
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            ops_a[i*96 +: 96] = {opa[i][2], opa[i][1], opa[i][0]};
            ops_b[i*96 +: 96] = {opb[i][2], opb[i][1], opb[i][0]};
        end
    endtask

    task automatic set_rand_ops(input int i);
        for (int j = 0; j < 3; j++) begin
            opa[i][j] = $urandom;
            opb[i][j] = $urandom;
        end
        drive_ops();
    endtask

    // One negedge; the engine model counts cycles out of reset and raises ready in its L-th.
    task automatic tick();
        @(negedge CLK2);
        if (!eng_rst_n) begin
            ecnt = 0;
            mrdy = 1'b0;
        end else begin
            ecnt = ecnt + 1;
            mrdy = (ecnt >= eng_lat);
        end
    endtask

    task automatic reset_dut();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic check_outs_zero(input string nm);
        check({nm, "_ctl"}, 64'({gnt, eng_rst_n, done, err, res_id}), 64'h0);
        check({nm, "_res"}, 64'(res), 64'h0);
        check({nm, "_ea"}, {eng_a1, eng_a2}, 64'h0);
        check({nm, "_eab"}, {eng_a3, eng_b1}, 64'h0);
        check({nm, "_eb"}, {eng_b2, eng_b3}, 64'h0);
    endtask

    // Wait (bounded) for done; n is the number of negedges from the call to the done cycle.
    task automatic wait_txn(input int lat, input int stale_n, input logic [NREQ-1:0] add_mask,
                            input bit drop_on_gnt, output logic [NREQ-1:0] g, output int gc,
                            output logic [IDW-1:0] id, output logic [31:0] r, output logic e,
                            output int n);
        int c;
        bit seen;
        eng_lat = lat;
        g = '0; gc = -1; id = '0; r = '0; e = 1'b0; n = -1; c = 0; seen = 1'b0;
        while (!seen && c < 300) begin
            tick();
            c++;
            stale_force = (c <= stale_n);
            if (c == 3) req = req | add_mask;
            if (g == '0 && gnt != '0) begin
                g  = gnt;
                gc = c;
                if (drop_on_gnt) req = req & ~gnt;
            end
            if (done) begin
                seen = 1'b1;
                id = res_id; r = res; e = err; n = c;
            end
        end
        stale_force = 1'b0;
    endtask

    typedef struct {
        logic [NREQ-1:0] rq;
        int              lat;
        int              stale;
        int              exp_id;
    } vec_t;

    initial begin
        vec_t            tbl [7];
        logic [NREQ-1:0] g;
        logic [IDW-1:0]  id;
        logic [31:0]     r;
        logic            e;
        int              n, gc, mptr, expi, lat;
        bit              drop;

        // ptr starts at 0 and advances to granted+1 after every completion.
        tbl[0] = '{4'b0010, 5, 0, 1};
        tbl[1] = '{4'b0011, 2, 0, 0};
        tbl[2] = '{4'b1100, 3, 0, 2};
        tbl[3] = '{4'b1001, 4, 2, 3};
        tbl[4] = '{4'b0001, 2, 0, 0};
        tbl[5] = '{4'b1000, 6, 0, 3};
        tbl[6] = '{4'b0110, 3, 2, 1};

        RST = 1'b0; req = '0; ops_a = '0; ops_b = '0;
        for (int i = 0; i < NREQ; i++) set_rand_ops(i);
        opa[1][0] = 32'h4040_0000; opa[1][1] = 32'h0; opa[1][2] = 32'h0;
        opb[1][0] = 32'h4040_0000; opb[1][1] = 32'h0; opb[1][2] = 32'h0;
        drive_ops();
        tick();
        tick();
        check_outs_zero("reset");
        RST = 1'b1;

        for (int k = 0; k < 7; k++) begin
            req = tbl[k].rq;
            wait_txn(tbl[k].lat, tbl[k].stale, '0, 1'b0, g, gc, id, r, e, n);
            check($sformatf("tbl%0d_gnt", k), 64'(g), 64'(oh(tbl[k].exp_id)));
            check($sformatf("tbl%0d_gnt_cycle", k), 64'(gc), 64'(1));
            check($sformatf("tbl%0d_id", k), 64'(id), 64'(tbl[k].exp_id));
            check($sformatf("tbl%0d_res", k), 64'(r), 64'(exp_res(tbl[k].exp_id)));
            check($sformatf("tbl%0d_latency", k), 64'(n), 64'(tbl[k].lat + 2));
            check($sformatf("tbl%0d_err", k), 64'(e), 64'(0));
            req = '0;
            tick();
            check($sformatf("tbl%0d_done_pulse", k), 64'({done, gnt}), 64'(0));
        end
        check("single_res_const", 64'(exp_res(1)), 64'h4110_0000);

        // Round-robin with all requests held from ptr=0.
        reset_dut();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_txn(3, 0, '0, 1'b0, g, gc, id, r, e, n);
            check($sformatf("rr%0d_id", k), 64'(id), 64'(k % NREQ));
            check($sformatf("rr%0d_gnt", k), 64'(g), 64'(oh(k % NREQ)));
            check($sformatf("rr%0d_res", k), 64'(r), 64'(exp_res(k % NREQ)));
            check($sformatf("rr%0d_period", k), 64'(n), 64'((k == 0) ? 5 : 6));
        end
        req = '0;
        tick();

        // Fairness: req0 held, req2 joins during 0's RUN; ptr is 1 here.
        req = 4'b0001;
        wait_txn(4, 0, 4'b0100, 1'b0, g, gc, id, r, e, n);
        check("fair0_id", 64'(id), 64'(0));
        check("fair0_latency", 64'(n), 64'(6));
        wait_txn(4, 0, '0, 1'b0, g, gc, id, r, e, n);
        check("fair1_id", 64'(id), 64'(2));
        check("fair1_res", 64'(r), 64'(exp_res(2)));
        req[2] = 1'b0;
        wait_txn(4, 0, '0, 1'b0, g, gc, id, r, e, n);
        check("fair2_id", 64'(id), 64'(0));
        check("fair2_period", 64'(n), 64'(7));
        req = '0;
        tick();

        // Asynchronous reset in the middle of RUN.
        req = 4'b0010;
        eng_lat = 5;
        for (int c = 0; c < 4; c++) tick();
        check("midrun_gnt", 64'(gnt), 64'(4'b0010));
        RST = 1'b0;
        #1;
        check_outs_zero("midrun_rst");
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("midrun_nodone%0d", c), 64'({done, gnt}), 64'(0));
        end
        RST = 1'b1;
        req = 4'b0011;
        wait_txn(3, 0, '0, 1'b0, g, gc, id, r, e, n);
        check("after_rst_id", 64'(id), 64'(0));
        check("after_rst_res", 64'(r), 64'(exp_res(0)));
        check("after_rst_latency", 64'(n), 64'(5));
        req = '0;
        tick();

`ifdef VLEN_SCHED_TIMEOUT_EN
        req = 4'b0100;
        wait_txn(1000, 0, '0, 1'b0, g, gc, id, r, e, n);
        check("to_latency", 64'(n), 64'(TO + 2));
        check("to_err", 64'(e), 64'(1));
        check("to_res", 64'(r), 64'h7FC0_0000);
        check("to_id", 64'(id), 64'(2));
        req = 4'b1000;
        wait_txn(3, 0, '0, 1'b0, g, gc, id, r, e, n);
        check("to_next_id", 64'(id), 64'(3));
        check("to_next_err", 64'(e), 64'(0));
        check("to_next_res", 64'(r), 64'(exp_res(3)));
        req = '0;
        tick();
`endif

        // Randomized traffic against the rotating-priority model.
        reset_dut();
        mptr = 0;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_rand_ops(i);
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if (req == '0) begin
                expi = $urandom_range(0, NREQ - 1);
                set_rand_ops(expi);
                req[expi] = 1'b1;
            end
            expi = -1;
            for (int s = 0; s < NREQ; s++) begin
                if (expi < 0 && req[(mptr + s) % NREQ]) expi = (mptr + s) % NREQ;
            end
            lat  = $urandom_range(2, 6);
            drop = ($urandom_range(0, 3) == 0);
            wait_txn(lat, 0, '0, drop, g, gc, id, r, e, n);
            check($sformatf("rnd%0d_id", t), 64'(id), 64'(expi));
            check($sformatf("rnd%0d_gnt", t), 64'(g), 64'(oh(expi)));
            check($sformatf("rnd%0d_res", t), 64'(r), 64'(exp_res(expi)));
            check($sformatf("rnd%0d_latency", t), 64'(n), 64'(lat + 2));
            check($sformatf("rnd%0d_err", t), 64'(e), 64'(0));
            mptr = (expi + 1) % NREQ;
            req[expi] = 1'b0;
            tick();
            check($sformatf("rnd%0d_gnt_clear", t), 64'(gnt), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
